// File: rtl/ir_pkg.sv
// Shared types and default thresholds for the IR pulse-width frame receiver.
package ir_pkg;

    localparam int unsigned CW_DEF        = 5;
    localparam int unsigned LOW_MIN_DEF   = 3;
    localparam int unsigned HIGH_MIN_DEF  = 8;
    localparam int unsigned START_MIN_DEF = 14;
    localparam int unsigned GAP_MAX_DEF   = 20;
    localparam int unsigned NBITS_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SYM_GLITCH = 2'd0,
        SYM_ZERO   = 2'd1,
        SYM_ONE    = 2'd2,
        SYM_START  = 2'd3
    } sym_t;

endpackage

// File: rtl/ir_width_meas.sv
// Synchronizes the raw IR pin, measures the high width of each pulse and
// classifies it in the cycle its falling edge is seen.
module ir_width_meas
    import ir_pkg::*;
#(
    parameter int unsigned CW        = CW_DEF,
    parameter int unsigned LOW_MIN   = LOW_MIN_DEF,
    parameter int unsigned HIGH_MIN  = HIGH_MIN_DEF,
    parameter int unsigned START_MIN = START_MIN_DEF
) (
    input  logic clk,
    input  logic res,
    input  logic ir,
    output logic fe,
    output sym_t sym,
    output logic ir_s
);

    localparam logic [CW-1:0] W_MAX = '1;

    logic          ir_m;
    logic          ir_s_d;
    logic [CW-1:0] width;

    // Two-stage synchronizer, edge-detect delay and saturating width counter
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ir_m   <= 1'b0;
            ir_s   <= 1'b0;
            ir_s_d <= 1'b0;
            width  <= '0;
        end else begin
            ir_m   <= ir;
            ir_s   <= ir_m;
            ir_s_d <= ir_s;
            if (!ir_s) begin
                width <= '0;
            end else if (width != W_MAX) begin
                width <= width + CW'(1);
            end
        end
    end

    // A saturated width is always START, even if START_MIN exceeds the counter range
    always_comb begin
        fe  = ir_s_d & ~ir_s;
        sym = SYM_GLITCH;
        if (width == W_MAX || width >= CW'(START_MIN)) begin
            sym = SYM_START;
        end else if (width >= CW'(HIGH_MIN)) begin
            sym = SYM_ONE;
        end else if (width >= CW'(LOW_MIN)) begin
            sym = SYM_ZERO;
        end
    end

endmodule

// File: rtl/ir_frame_ctrl.sv
// IR frame receiver: START pulse then NBITS width-coded data pulses, assembled
// LSB-first and handed to the consumer over a rdy/ack handshake.
module ir_frame_ctrl
    import ir_pkg::*;
#(
    parameter int unsigned CW        = CW_DEF,
    parameter int unsigned LOW_MIN   = LOW_MIN_DEF,
    parameter int unsigned HIGH_MIN  = HIGH_MIN_DEF,
    parameter int unsigned START_MIN = START_MIN_DEF,
    parameter int unsigned GAP_MAX   = GAP_MAX_DEF,
    parameter int unsigned NBITS     = NBITS_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             ir,
    input  logic             ack,
    output logic             en,
    output logic             rdy,
    output logic             err,
    output logic             ovr,
    output logic [NBITS-1:0] data
);

    localparam int unsigned   BCW     = $clog2(NBITS + 1);
    localparam logic [CW-1:0] GAP_SAT = '1;

    state_t           state;
    logic             fe;
    sym_t             sym;
    logic             ir_s;
    logic [NBITS-1:0] sr;
    logic [BCW-1:0]   bit_cnt;
    logic [CW-1:0]    gap_cnt;

    ir_width_meas #(
        .CW        (CW),
        .LOW_MIN   (LOW_MIN),
        .HIGH_MIN  (HIGH_MIN),
        .START_MIN (START_MIN)
    ) u_meas (
        .clk  (clk),
        .res  (res),
        .ir   (ir),
        .fe   (fe),
        .sym  (sym),
        .ir_s (ir_s)
    );

    // Frame sequencer; gap counter is implicitly cleared on BITS entry because it only runs in BITS
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state   <= IDLE;
            en      <= 1'b0;
            rdy     <= 1'b0;
            err     <= 1'b0;
            ovr     <= 1'b0;
            data    <= '0;
            sr      <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            err <= 1'b0;

            if (state == BITS && !ir_s) begin
                if (gap_cnt != GAP_SAT) begin
                    gap_cnt <= gap_cnt + CW'(1);
                end
            end else begin
                gap_cnt <= '0;
            end

            if (ack && rdy) begin
                rdy <= 1'b0;
                ovr <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fe && sym == SYM_START) begin
                        state   <= BITS;
                        en      <= 1'b1;
                        bit_cnt <= '0;
                        sr      <= '0;
                    end
                end

                BITS: begin
                    if (fe) begin
                        case (sym)
                            SYM_START: begin
                                bit_cnt <= '0;
                                sr      <= '0;
                            end
                            SYM_GLITCH: begin
                                err   <= 1'b1;
                                en    <= 1'b0;
                                state <= IDLE;
                            end
                            default: begin
                                sr      <= {sym == SYM_ONE, sr[NBITS-1:1]};
                                bit_cnt <= bit_cnt + BCW'(1);
                                if (bit_cnt == BCW'(NBITS - 1)) begin
                                    en    <= 1'b0;
                                    state <= DONE;
                                end
                            end
                        endcase
                    end else if (gap_cnt >= CW'(GAP_MAX)) begin
                        err   <= 1'b1;
                        en    <= 1'b0;
                        state <= IDLE;
                    end
                end

                DONE: begin
                    // New frame wins over a coincident ack; unacked old data is an overrun
                    data  <= sr;
                    rdy   <= 1'b1;
                    state <= IDLE;
                    if (rdy && !ack) begin
                        ovr <= 1'b1;
                    end
                end

                default: begin
                    en    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_frame_ctrl.sv
// Directed self-checking bench for ir_frame_ctrl.
module tb_ir_frame_ctrl;

    logic       clk;
    logic       res;
    logic       ir;
    logic       ack;
    logic       en;
    logic       rdy;
    logic       err;
    logic       ovr;
    logic [7:0] data;

    int n_tests;
    int n_fail;
    int err_cnt;

    ir_frame_ctrl dut (
        .clk  (clk),
        .res  (res),
        .ir   (ir),
        .ack  (ack),
        .en   (en),
        .rdy  (rdy),
        .err  (err),
        .ovr  (ovr),
        .data (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each cycle err is high adds one, so a single-cycle pulse adds exactly one
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
    end

    task automatic pulse(input int hi, input int lo);
        ir = 1'b1;
        repeat (hi) @(negedge clk);
        ir = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input int w1, input int w0);
        for (int i = 0; i < n; i++) begin
            pulse(b[i] ? w1 : w0, 6);
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        pulse(16, 6);
        send_bits(b, 8, 10, 5);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        res = 1'b0; ir = 1'b0; ack = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({en, rdy, err, ovr} !== 4'b0000 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got en=%b rdy=%b err=%b ovr=%b data=%h expected all 0", en, rdy, err, ovr, data);
        end
        res = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clean();
        int e0;
        e0 = err_cnt;
        pulse(16, 6);
        n_tests++;
        if (en !== 1'b1) begin n_fail++; $display("FAIL clean_en_frame: got %b expected 1", en); end
        send_bits(8'hA5, 7, 10, 5);
        ir = 1'b1;
        repeat (10) @(negedge clk);
        ir = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (rdy !== 1'b0) begin n_fail++; $display("FAIL clean_rdy_early: got %b expected 0", rdy); end
        @(negedge clk);
        n_tests++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL clean_rdy_latency: got %b expected 1", rdy); end
        n_tests++;
        if (data !== 8'hA5) begin n_fail++; $display("FAIL clean_data: got %h expected a5", data); end
        n_tests++;
        if (en !== 1'b0 || ovr !== 1'b0) begin n_fail++; $display("FAIL clean_en_ovr: got en=%b ovr=%b expected 0 0", en, ovr); end
        n_tests++;
        if (err_cnt !== e0) begin n_fail++; $display("FAIL clean_err: got %0d err cycles expected 0", err_cnt - e0); end
    endtask

    task automatic test_handshake();
        int bad;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy !== 1'b1 || data !== 8'hA5) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL hs_hold: %0d cycles lost rdy/data, expected 0", bad); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_tests++;
        if (rdy !== 1'b0) begin n_fail++; $display("FAIL hs_release: got rdy=%b expected 0", rdy); end
        do_ack();
        n_tests++;
        if (rdy !== 1'b0 || ovr !== 1'b0 || data !== 8'hA5) begin
            n_fail++;
            $display("FAIL hs_idle_ack: got rdy=%b ovr=%b data=%h expected 0 0 a5", rdy, ovr, data);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h3C);
        n_tests++;
        if (rdy !== 1'b1 || data !== 8'h3C || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_first: got rdy=%b data=%h ovr=%b expected 1 3c 0", rdy, data, ovr);
        end
        send_frame(8'hC3);
        n_tests++;
        if (rdy !== 1'b1 || data !== 8'hC3 || ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_second: got rdy=%b data=%h ovr=%b expected 1 c3 1", rdy, data, ovr);
        end
        do_ack();
        n_tests++;
        if (rdy !== 1'b0 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_ack: got rdy=%b ovr=%b expected 0 0", rdy, ovr);
        end
    endtask

    task automatic test_ack_collide();
        send_frame(8'h11);
        pulse(16, 6);
        send_bits(8'h22, 7, 10, 5);
        ir = 1'b1;
        repeat (5) @(negedge clk);
        ir = 1'b0;
        repeat (3) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_tests++;
        if (rdy !== 1'b1 || data !== 8'h22 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL collide: got rdy=%b data=%h ovr=%b expected 1 22 0", rdy, data, ovr);
        end
        do_ack();
    endtask

    task automatic test_glitch();
        int e0;
        e0 = err_cnt;
        pulse(2, 6);
        pulse(5, 6);
        n_tests++;
        if (err_cnt !== e0 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: got err cycles=%0d en=%b expected 0 0", err_cnt - e0, en);
        end
        pulse(16, 6);
        send_bits(8'hFF, 3, 10, 5);
        pulse(2, 6);
        n_tests++;
        if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL glitch_err: got %0d err cycles expected 1", err_cnt - e0); end
        n_tests++;
        if (en !== 1'b0 || rdy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got en=%b rdy=%b expected 0 0", en, rdy); end
    endtask

    task automatic test_timeout();
        int e0;
        send_frame(8'h5A);
        e0 = err_cnt;
        pulse(16, 6);
        send_bits(8'hFF, 2, 10, 5);
        pulse(10, 25);
        n_tests++;
        if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL timeout_err: got %0d err cycles expected 1", err_cnt - e0); end
        n_tests++;
        if (en !== 1'b0 || rdy !== 1'b1 || data !== 8'h5A || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: got en=%b rdy=%b data=%h ovr=%b expected 0 1 5a 0", en, rdy, data, ovr);
        end
        do_ack();
    endtask

    task automatic test_restart();
        int e0;
        e0 = err_cnt;
        pulse(16, 6);
        send_bits(8'hFF, 3, 10, 5);
        pulse(16, 6);
        n_tests++;
        if (en !== 1'b1 || err_cnt !== e0) begin
            n_fail++;
            $display("FAIL restart_en: got en=%b err cycles=%0d expected 1 0", en, err_cnt - e0);
        end
        send_bits(8'h0F, 8, 10, 5);
        n_tests++;
        if (rdy !== 1'b1 || data !== 8'h0F) begin
            n_fail++;
            $display("FAIL restart_data: got rdy=%b data=%h expected 1 0f", rdy, data);
        end
        do_ack();
    endtask

    task automatic test_boundaries();
        pulse(14, 6);
        send_bits(8'h96, 8, 8, 3);
        n_tests++;
        if (rdy !== 1'b1 || data !== 8'h96) begin
            n_fail++;
            $display("FAIL bound_min: got rdy=%b data=%h expected 1 96", rdy, data);
        end
        do_ack();
        pulse(40, 6);
        send_bits(8'h69, 8, 13, 7);
        n_tests++;
        if (rdy !== 1'b1 || data !== 8'h69) begin
            n_fail++;
            $display("FAIL bound_max: got rdy=%b data=%h expected 1 69", rdy, data);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        pulse(16, 6);
        send_bits(8'hFF, 2, 10, 5);
        res = 1'b0;
        #1;
        n_tests++;
        if (en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_en: got %b expected 0", en); end
        @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'h81);
        send_frame(8'h42);
        n_tests++;
        if (rdy !== 1'b1 || ovr !== 1'b1 || data !== 8'h42) begin
            n_fail++;
            $display("FAIL rst_pre: got rdy=%b ovr=%b data=%h expected 1 1 42", rdy, ovr, data);
        end
        res = 1'b0;
        #1;
        n_tests++;
        if ({en, rdy, err, ovr} !== 4'b0000 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_rdy: got en=%b rdy=%b err=%b ovr=%b data=%h expected all 0", en, rdy, err, ovr, data);
        end
        @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'hE7);
        n_tests++;
        if (rdy !== 1'b1 || ovr !== 1'b0 || data !== 8'hE7) begin
            n_fail++;
            $display("FAIL rst_after: got rdy=%b ovr=%b data=%h expected 1 0 e7", rdy, ovr, data);
        end
        do_ack();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        err_cnt = 0;
        test_reset();
        test_clean();
        test_handshake();
        test_overrun();
        test_ack_collide();
        test_glitch();
        test_timeout();
        test_restart();
        test_boundaries();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_frame_ctrl.md
Name: ir_frame_ctrl

Overview:
- Sequences IR pulse-width measurement and assembles classified pulses into a framed 8-bit byte.
- A frame is one START pulse followed by NBITS data pulses. Each data pulse is classified as 0 or 1 by its width.
- Sits between the raw IR input pin and the consumer logic. Presents data with a rdy/ack handshake.
- Detects glitches, inter-pulse timeouts and overruns.

Parameters:
- CW, 5: width-counter width; the counter saturates at 2^CW-1.
- LOW_MIN, 3: minimum high width, in clocks, for a valid bit-0 pulse.
- HIGH_MIN, 8: minimum high width for a bit-1 pulse.
- START_MIN, 14: minimum high width for a START pulse.
- GAP_MAX, 20: maximum low gap, in clocks, between pulses inside a frame.
- NBITS, 8: data pulses per frame.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous active-low reset.
- ir  in  1  raw IR demodulated input; active-high pulses; asynchronous to clk.
- ack  in  1  consumer acknowledge; single-cycle or held.
- en  out  1  high while a frame is being received (states START_WAIT and BITS).
- rdy  out  1  data valid; held until ack.
- err  out  1  one-cycle pulse on a frame abort (glitch or timeout).
- ovr  out  1  sticky overrun flag; cleared by ack.
- data  out  8  last completed frame, LSB-first order.

Behaviour:

Reset:
- res=0 asynchronously clears everything: state=IDLE, en=0, rdy=0, err=0, ovr=0, data=8'h00, shift register=0, bit count=0, width counter=0, gap counter=0, synchronizer flops=0.
- Reset applied mid-frame discards the partial frame.

Input conditioning:
- ir passes through a 2-FF synchronizer to give ir_s. ir_s_d is ir_s delayed one cycle.
- A falling edge (fe) is ir_s_d=1 and ir_s=0.

Width counter:
- Cleared while ir_s=0.
- Increments, saturating, while ir_s=1.
- An input pulse sampled high for P clocks gives w=P at fe.

Classification, evaluated only in the fe cycle:
- w >= START_MIN: START.
- HIGH_MIN <= w < START_MIN: ONE.
- LOW_MIN <= w < HIGH_MIN: ZERO.
- w < LOW_MIN: GLITCH.

Gap counter:
- Counts clocks with ir_s=0 while in BITS.
- Cleared on any ir_s=1 and on BITS entry.
- Saturates at 2^CW-1.

States and transitions:
- IDLE:
  - fe with START goes to BITS; the bit count is cleared.
  - All other fe classes are ignored; err is not asserted.
- START_WAIT:
  - A one-cycle alias of entry into BITS. It may be merged with BITS, provided en behaves identically.
- BITS:
  - fe with ZERO or ONE: shift register <= {bit, sr[7:1]}; bit count increments.
  - When the bit count reaches NBITS, go to DONE.
  - fe with START: restart the frame. Bit count=0, stay in BITS, no err.
  - fe with GLITCH: err pulses; go to IDLE.
  - Gap counter reaching GAP_MAX: err pulses; go to IDLE.
- DONE (one cycle):
  - data <= sr and rdy <= 1.
  - If rdy was already 1 and ack is not asserted this cycle, ovr <= 1.
  - Go to IDLE.

Timing and handshake:
- Latency: rdy rises on the clk edge following the edge on which the NBITS-th bit is classified. That is 4 clocks after the last ir fall reaches the synchronizer input.
- rdy/ack: rdy falls on the edge after ack=1 is sampled. ack=1 also clears ovr.
- ack while rdy=0 has no effect.
- If ack and DONE occur in the same cycle, the new frame wins: rdy stays 1, data is updated, ovr is not set.
- data changes only in DONE. It is stable while rdy=1 unless an overrun occurs; on overrun the newest frame overwrites data.
- err pulses for exactly one cycle and does not affect rdy, data or ovr.

Width rules:
- Comparisons are unsigned, CW bits wide.
- A saturated width always classifies as START.

Decomposition:
- Package ir_pkg:
  - state enum {IDLE, BITS, DONE}.
  - symbol enum {SYM_GLITCH, SYM_ZERO, SYM_ONE, SYM_START}.
  - Default threshold constants.
- Sub-module ir_width_meas: synchronizer, saturating width counter, fe detect and classification.
  - Outputs: fe, sym, ir_s.
- The controller FSM, shift register, gap counter and handshake stay in ir_frame_ctrl.

Test Plan:
- Clean frame: START of 16 clocks, then bits 1,0,1,0,0,1,0,1. A 1 is 10 clocks high, a 0 is 5 clocks high, gaps are 6 clocks low. Expect data=8'hA5, rdy=1 four clocks after the last fall, en=0 after DONE, err=0.
- Handshake: hold ack=0 for 50 clocks, then pulse ack. Expect rdy=1 and data stable throughout, then rdy=0 on the next edge.
- Overrun: send two full frames, 8'h3C then 8'hC3, with no ack. Expect data=8'hC3, ovr=1. Then ack: expect rdy=0, ovr=0.
- Glitch and timeout: after START and 3 bits, send a 2-clock pulse. Expect a 1-cycle err and IDLE. Repeat with a 25-clock gap after bit 3: expect err and en=0, with rdy unchanged.
- Restart and boundaries:
  - A second START mid-frame, then 8 bits of 8'h0F: expect data=8'h0F.
  - Pulses of exactly 3, 8 and 14 clocks classify as ZERO, ONE and START respectively.
- Reset: assert res low mid-frame and again while rdy=1. Expect all outputs 0 immediately, and a subsequent frame decodes correctly.
